// File: rtl/bram_fifo_controller.sv
// FIFO control stage for an external one-cycle-latency BRAM.
// First-word-fall-through output from a head/skid pair.
module bram_fifo_controller #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    output logic                         full,
    output logic                         overflow,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         pop_valid,
    output logic [$clog2(DEPTH+3)-1:0]   count,
    output logic                         mem_write_enable,
    output logic [$clog2(DEPTH)-1:0]     mem_write_addr,
    output logic [WIDTH-1:0]             mem_write_data,
    output logic                         mem_read_enable,
    output logic [$clog2(DEPTH)-1:0]     mem_read_addr,
    input  logic [WIDTH-1:0]             mem_read_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 3);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    mem_count_q, mem_count_d;
    logic             in_flight_q, in_flight_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             head_v_q, head_v_d;
    logic             skid_v_q, skid_v_d;

    logic       accept;
    logic       issue;
    logic       pop_fire;
    logic [1:0] out_entries;
    logic [2:0] occ;
    logic [2:0] limit;

    assign accept      = push && !full_q;
    assign pop_fire    = pop && head_v_q;
    assign out_entries = {1'b0, head_v_q} + {1'b0, skid_v_q};
    assign occ         = {1'b0, out_entries} + {2'b00, in_flight_q};
    assign limit       = 3'd2 + {2'b00, pop_fire};
    // Only issue a read if the buffer will have a slot when the data lands.
    assign issue       = (mem_count_q != '0) && (occ < limit);

    assign wr_ptr_d    = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d    = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign mem_count_d = mem_count_q + CW'(accept) - CW'(issue);
    assign full_d      = (mem_count_d == CW'(DEPTH));
    assign overflow_d  = push && full_q;
    assign in_flight_d = issue;

    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (pop_fire) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                skid_v_d = in_flight_q;
                if (in_flight_q) skid_d = mem_read_data;
            end else begin
                head_v_d = in_flight_q;
                if (in_flight_q) head_d = mem_read_data;
            end
        end else if (in_flight_q) begin
            if (head_v_q) begin
                skid_d   = mem_read_data;
                skid_v_d = 1'b1;
            end else begin
                head_d   = mem_read_data;
                head_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            in_flight_q <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            head_q      <= '0;
            skid_q      <= '0;
            head_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            in_flight_q <= in_flight_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            head_v_q    <= head_v_d;
            skid_v_q    <= skid_v_d;
        end
    end

    assign full             = full_q;
    assign overflow         = overflow_q;
    assign pop_data         = head_q;
    assign pop_valid        = head_v_q;
    assign count            = mem_count_q + CW'(in_flight_q) + CW'(out_entries);
    assign mem_write_enable = accept;
    assign mem_write_addr   = wr_ptr_q;
    assign mem_write_data   = push_data;
    assign mem_read_enable  = issue;
    assign mem_read_addr    = rd_ptr_q;

endmodule

// File: tb/tb_bram_fifo_controller.sv
// Bench for bram_fifo_controller (DEPTH=16) with a behavioural BRAM
// and a queue-based scoreboard of accepted words.
module tb_bram_fifo_controller;

    localparam int W = 8;
    localparam int D = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         push = 1'b0;
    logic [W-1:0] push_data = '0;
    logic         full, overflow, pop_valid;
    logic         pop = 1'b0;
    logic [W-1:0] pop_data;
    logic [4:0]   count;
    logic         mem_write_enable, mem_read_enable;
    logic [3:0]   mem_write_addr, mem_read_addr;
    logic [W-1:0] mem_write_data, mem_read_data;

    logic [W-1:0] mem [D];
    logic [W-1:0] rdata_q = '0;

    int vec = 0;
    int errs = 0;
    int q[$];
    logic ovf_exp = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;
        if (mem_read_enable) rdata_q <= mem[mem_read_addr];
    end
    assign mem_read_data = rdata_q;

    bram_fifo_controller #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .push(push), .push_data(push_data),
        .full(full), .overflow(overflow),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .count(count),
        .mem_write_enable(mem_write_enable),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_read_enable(mem_read_enable),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data)
    );

    typedef struct {
        logic       p;
        logic [7:0] d;
        logic       pp;
        logic       pv;
        logic [7:0] pd;
        int         cnt;
        logic       we;
        logic       re;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Scoreboard update for the edge ending the current cycle.
    task automatic model_update(input logic p, input logic [7:0] d,
                                input logic pp);
        ovf_exp = p && full;
        if (pp && pop_valid && q.size() > 0) void'(q.pop_front());
        if (p && !full) q.push_back(int'(d));
    endtask

    task automatic step(input logic p, input logic [7:0] d, input logic pp);
        @(negedge clock);
        push = p; push_data = d; pop = pp;
        #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(ovf_exp));
        if (pop_valid) begin
            chk("pv_nonempty", 32'(q.size() > 0), 32'(1));
            if (q.size() > 0) chk("pop_data", 32'(pop_data), 32'(q[0]));
        end
        if (q.size() < D) chk("full_low", 32'(full), 32'(0));
        if (q.size() == D + 2) chk("full_high", 32'(full), 32'(1));
        model_update(p, d, pp);
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; push_data = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
        #1;
        chk("rst_pv", 32'(pop_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_pd", 32'(pop_data), 32'(0));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk(name, 32'(q.size()), 32'(0));
        step(1'b0, 8'h00, 1'b0);
        chk({name, "_pv"}, 32'(pop_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};

        do_reset();

        // single-word latency
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            push = tbl[i].p; push_data = tbl[i].d; pop = tbl[i].pp;
            #1;
            chk("lat_pv", 32'(pop_valid), 32'(tbl[i].pv));
            if (tbl[i].pv) chk("lat_pd", 32'(pop_data), 32'(tbl[i].pd));
            chk("lat_cnt", 32'(count), 32'(tbl[i].cnt));
            chk("lat_we", 32'(mem_write_enable), 32'(tbl[i].we));
            chk("lat_re", 32'(mem_read_enable), 32'(tbl[i].re));
            if (tbl[i].we) chk("lat_wa", 32'(mem_write_addr), 32'(0));
            model_update(tbl[i].p, tbl[i].d, tbl[i].pp);
        end

        // burst in, burst out with no bubbles
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk("burst_cnt", 32'(count), 32'(16));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("burst_pv", 32'(pop_valid), 32'(1));
            chk("burst_pd", 32'(pop_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b0);
        chk("burst_end_pv", 32'(pop_valid), 32'(0));
        chk("burst_end_cnt", 32'(count), 32'(0));

        // fill to full, then overflow
        for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_cnt", 32'(count), 32'(18));
        step(1'b1, 8'hEE, 1'b0);
        chk("ovf_before", 32'(overflow), 32'(0));
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'(1));
        chk("ovf_cnt", 32'(count), 32'(18));
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_after", 32'(overflow), 32'(0));
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("fill_pd", 32'(pop_data), 32'(8'h40 + i));
        end
        step(1'b0, 8'h00, 1'b0);
        chk("fill_end_cnt", 32'(count), 32'(0));

        // streaming across pointer wrap
        do_reset();
        for (int i = 0; i < 3 * D; i++) begin
            step(1'b1, 8'(i), 1'b1);
            if (i >= 3) chk("stream_pv", 32'(pop_valid), 32'(1));
            if (i >= 4) chk("stream_cnt", 32'(count), 32'(3));
        end
        drain("stream_drain");

        // random push/pop with stalls
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 1)));
        drain("rand_drain");

        // reset with a read in flight
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        push = 1'b0; pop = 1'b0;
        #1;
        chk("pre_rst_cnt", 32'(count), 32'(5));
        reset = 1'b1;
        #1;
        chk("arst_pv", 32'(pop_valid), 32'(0));
        chk("arst_cnt", 32'(count), 32'(0));
        chk("arst_full", 32'(full), 32'(0));
        chk("arst_pd", 32'(pop_data), 32'(0));
        chk("arst_re", 32'(mem_read_enable), 32'(0));
        q.delete();
        ovf_exp = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_c1_pv", 32'(pop_valid), 32'(0));
        step(1'b0, 8'h00, 1'b0);
        chk("post_c2_pv", 32'(pop_valid), 32'(0));
        step(1'b0, 8'h00, 1'b1);
        chk("post_c3_pv", 32'(pop_valid), 32'(1));
        chk("post_c3_pd", 32'(pop_data), 32'(8'h3C));
        step(1'b0, 8'h00, 1'b0);
        chk("post_end_pv", 32'(pop_valid), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
